// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (busy + producing ROB id) and two read ports.
// Optional same-cycle commit-to-read forwarding is enabled by defining RF_COMMIT_BYPASS_EN.
module register_file #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ROB_AW = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic              _rf_launch_ready,
  input  logic [ROB_AW-1:0] _rf_launch_rob_id,
  input  logic [REG_AW-1:0] _rf_launch_register_id,
  input  logic              _rf_commit_ready,
  input  logic [ROB_AW-1:0] _rf_commit_rob_id,
  input  logic [REG_AW-1:0] _rf_commit_register_id,
  input  logic [XLEN-1:0]   _rf_commit_value,
  input  logic [REG_AW-1:0] _rf_get_id_1,
  output logic              _rf_busy_1,
  output logic [ROB_AW-1:0] _rf_dep_1,
  output logic [XLEN-1:0]   _rf_value_1,
  input  logic [REG_AW-1:0] _rf_get_id_2,
  output logic              _rf_busy_2,
  output logic [ROB_AW-1:0] _rf_dep_2,
  output logic [XLEN-1:0]   _rf_value_2
);

  localparam int NREG = 2 ** REG_AW;

  logic [XLEN-1:0]   r_value [NREG];
  logic [ROB_AW-1:0] r_tag   [NREG];
  logic [NREG-1:0]   r_busy;

  logic w_launch_en;
  logic w_commit_en;
  logic w_release;

  assign w_launch_en = _rf_launch_ready && (_rf_launch_register_id != '0) && !_clear;
  assign w_commit_en = _rf_commit_ready && (_rf_commit_register_id != '0);
  // A commit only frees the register if it is still the newest producer and no new one claims it now.
  assign w_release   = w_commit_en
                     && (r_tag[_rf_commit_register_id] == _rf_commit_rob_id)
                     && !(w_launch_en && (_rf_launch_register_id == _rf_commit_register_id));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy <= '0;
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_value[_rf_commit_register_id] <= _rf_commit_value;
      end
      if (_clear) begin
        r_busy <= '0;
      end else begin
        if (w_release) begin
          r_busy[_rf_commit_register_id] <= 1'b0;
        end
        if (w_launch_en) begin
          r_busy[_rf_launch_register_id] <= 1'b1;
          r_tag[_rf_launch_register_id]  <= _rf_launch_rob_id;
        end
      end
    end
  end

`ifdef RF_COMMIT_BYPASS_EN
  logic w_bypass;
  assign w_bypass = rst_in && rdy_in && w_release;
`endif

  logic [REG_AW-1:0] w_get_id [2];
  assign w_get_id[0] = _rf_get_id_1;
  assign w_get_id[1] = _rf_get_id_2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic              w_busy;
      logic [ROB_AW-1:0] w_dep;
      logic [XLEN-1:0]   w_value;

      always_comb begin
        w_busy  = 1'b0;
        w_dep   = '0;
        w_value = '0;
        if (w_get_id[gi] != '0) begin
`ifdef RF_COMMIT_BYPASS_EN
          if (w_bypass && (w_get_id[gi] == _rf_commit_register_id)) begin
            w_value = _rf_commit_value;
          end else
`endif
          begin
            w_value = r_value[w_get_id[gi]];
            if (r_busy[w_get_id[gi]]) begin
              w_busy = 1'b1;
              w_dep  = r_tag[w_get_id[gi]];
            end
          end
        end
      end
    end
  endgenerate

  assign _rf_busy_1  = g_rd[0].w_busy;
  assign _rf_dep_1   = g_rd[0].w_dep;
  assign _rf_value_1 = g_rd[0].w_value;
  assign _rf_busy_2  = g_rd[1].w_busy;
  assign _rf_dep_2   = g_rd[1].w_dep;
  assign _rf_value_2 = g_rd[1].w_value;

endmodule
